core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Top-level instruction sequencer for the multi-cycle core. It drives the five stages in order: fetch, decode, exec, mem, write.
- Each stage gets a one-cycle enable pulse; the sequencer then waits for that stage's done pulse before moving on.
- Owns the architectural PC. On an instruction boundary the PC is updated from the write stage's pcenable/next_pc, otherwise it advances by 4.
- Also provides halt/resume at instruction boundaries, a per-stage watchdog and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0, PC value after reset.
- TIMEOUT, 1024, maximum cycles a stage may take before an error is raised; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  pulse; leaves IDLE
- halt_req  in  1  level; request to stop at the next instruction boundary
- fetch_enable  out  1  one-cycle pulse
- fetch_done  in  1  fetch complete
- decode_enable  out  1  one-cycle pulse
- decode_done  in  1  decode complete
- mem_skip  in  1  sampled with decode_done; 1 = instruction has no mem stage
- exec_enable  out  1  one-cycle pulse
- exec_done  in  1  exec complete
- mem_enable  out  1  one-cycle pulse
- mem_done  in  1  mem complete
- write_enable  out  1  one-cycle pulse
- write_done  in  1  write complete
- pcenable  in  1  branch/jump taken; from the write stage
- next_pc  in  32  target PC, valid with pcenable
- pc  out  32  current instruction PC
- busy  out  1  1 in any stage state
- halted  out  1  1 in HALT
- error  out  1  sticky watchdog error
- err_stage  out  3  failing stage: 1 fetch, 2 decode, 3 exec, 4 mem, 5 write; 0 if none
- retired  out  CNT_W  instructions completed; wraps

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=IDLE; pc=RESET_PC.
  - All enables, busy, halted, error = 0; err_stage=0; retired=0; jump latch cleared.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WRITE, HALT, ERROR.
- Stage entry:
  - Entering a stage state asserts its *_enable in the first cycle in that state only.
  - The done input is ignored in that enable cycle and sampled from the next cycle on.
  - Done seen in cycle t gives the next stage's enable at t+1. Minimum cost is 2 cycles per stage.
- Transitions:
  - IDLE: start=1 and halt_req=0 -> FETCH. If start=1 and halt_req=1 -> HALT. start outside IDLE is ignored.
  - FETCH -> DECODE.
  - DECODE -> EXEC; mem_skip is latched at decode_done.
  - EXEC -> MEM, or -> WRITE if the latched mem_skip=1.
  - MEM -> WRITE.
  - WRITE -> FETCH, or -> HALT if halt_req=1 in the write_done cycle.
  - HALT: halted=1; halt_req=0 -> FETCH at the same pc.
  - ERROR: terminal until reset.
- PC update:
  - pcenable is observed only in WRITE. It latches next_pc into a jump target and sets the jump flag. pcenable outside WRITE is ignored.
  - At write_done: pc <= next_pc if pcenable is set that same cycle, else the latched target if the jump flag is set, else pc+4 modulo 2^32 (32'hFFFFFFFC -> 32'h0).
  - The jump flag clears at write_done.
  - pc is stable from FETCH entry until write_done.
- retired: incremented at each write_done; wraps to 0.
- Watchdog:
  - A cycle counter resets on every state entry.
  - In a stage state, if the counter reaches TIMEOUT-1 with no done -> ERROR, error=1, err_stage = stage code.
  - If done arrives in the expiry cycle, done wins.
  - Inactive in IDLE, HALT and ERROR.
- busy = 1 in FETCH..WRITE. halted = 1 in HALT. Outputs are registered.
- Reset mid-instruction: immediate return to reset values. Any in-flight stage done arriving after reset is ignored (state is IDLE).

Decomposition:
- Shared package core_pkg holds:
  - the state enum;
  - stage codes (STG_NONE=0 .. STG_WRITE=5);
  - WORD_W=32;
  - PC_STEP=4.
- Sub-module stage_watchdog: counter, restart, enable and expire output, parameterised by TIMEOUT.

Test Plan:
1. Reset, start; every stage done 1 cycle after its enable, mem_skip=0 -> enables in order, fetch_enable every 10 cycles, pc 0,4,8; retired=3 after 3 instructions.
2. mem_skip=1 at decode_done -> no mem_enable; write_enable 1 cycle after exec_done; pc+4.
3. pcenable, next_pc=32'h100 one cycle before write_done, then the same case with pcenable coincident with write_done -> pc=32'h100 in both; next instruction pc=32'h104.
4. halt_req=1 during EXEC -> instruction completes, halted=1, no fetch_enable. Release halt_req -> fetch_enable next cycle with the unchanged pc.
5. TIMEOUT=8, exec_done withheld -> error=1, err_stage=3 after 8 cycles in EXEC, sticky. A late exec_done has no effect.
6. RESET_PC=32'hFFFFFFFC, one instruction -> pc wraps to 0. Assert rstn=0 mid-DECODE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    // The five stage states are numbered 1..5 so that their encoding equals
    // the stage code reported on err_stage.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [2:0] STG_NONE   = 3'd0;
    localparam logic [2:0] STG_FETCH  = 3'd1;
    localparam logic [2:0] STG_DECODE = 3'd2;
    localparam logic [2:0] STG_EXEC   = 3'd3;
    localparam logic [2:0] STG_MEM    = 3'd4;
    localparam logic [2:0] STG_WRITE  = 3'd5;

    // True for the states that drive a pipeline stage.
    function automatic logic is_stage(input state_t s);
        return s inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WRITE};
    endfunction

    // Stage code of a state; STG_NONE for non-stage states.
    function automatic logic [2:0] stage_code(input state_t s);
        logic [2:0] code;
        case (s)
            ST_FETCH:  code = STG_FETCH;
            ST_DECODE: code = STG_DECODE;
            ST_EXEC:   code = STG_EXEC;
            ST_MEM:    code = STG_MEM;
            ST_WRITE:  code = STG_WRITE;
            default:   code = STG_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle watchdog: counts cycles spent in the current state and
// flags expiry when the count reaches TIMEOUT-1. TIMEOUT=0 disables it.
module stage_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count_reg;

    // Cycle counter: cleared on state entry, saturates at the expiry value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (restart) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            assign expire = enable && (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: walks fetch/decode/exec/mem/write, owns the PC,
// supports halt at instruction boundaries, a stage watchdog and a retire count.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0,
    parameter int                TIMEOUT  = 1024,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              halt_req,
    output logic              fetch_enable,
    input  logic              fetch_done,
    output logic              decode_enable,
    input  logic              decode_done,
    input  logic              mem_skip,
    output logic              exec_enable,
    input  logic              exec_done,
    output logic              mem_enable,
    input  logic              mem_done,
    output logic              write_enable,
    input  logic              write_done,
    input  logic              pcenable,
    input  logic [WORD_W-1:0] next_pc,
    output logic [WORD_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [2:0]        err_stage,
    output logic [CNT_W-1:0]  retired
);

    state_t            state_reg, state_next;
    logic              entry_reg;
    logic              skip_reg;
    logic              jump_reg;
    logic [WORD_W-1:0] target_reg;
    logic [WORD_W-1:0] pc_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic              error_reg;
    logic [2:0]        err_stage_reg;
    logic [4:0]        en_reg, en_next;
    logic              busy_reg, busy_next;
    logic              halted_reg, halted_next;
    logic              cur_done;
    logic              stage_done;
    logic              wd_expire;
    logic              write_fire;

    stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rstn    (rstn),
        .restart (state_next != state_reg),
        .enable  (is_stage(state_reg)),
        .expire  (wd_expire)
    );

    // Select the done input of the active stage.
    always_comb begin
        cur_done = 1'b0;
        case (state_reg)
            ST_FETCH:  cur_done = fetch_done;
            ST_DECODE: cur_done = decode_done;
            ST_EXEC:   cur_done = exec_done;
            ST_MEM:    cur_done = mem_done;
            ST_WRITE:  cur_done = write_done;
            default:   cur_done = 1'b0;
        endcase
    end

    // Done is ignored in the enable cycle of a stage.
    assign stage_done = cur_done && !entry_reg;
    assign write_fire = (state_reg == ST_WRITE) && stage_done;

    // State register; entry_reg marks the first cycle in a new state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            entry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            entry_reg <= (state_next != state_reg);
        end
    end

    // Next-state logic; a done arriving in the expiry cycle still wins.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = halt_req ? ST_HALT : ST_FETCH;
            ST_FETCH:  if (stage_done) state_next = ST_DECODE;
            ST_DECODE: if (stage_done) state_next = ST_EXEC;
            ST_EXEC:   if (stage_done) state_next = skip_reg ? ST_WRITE : ST_MEM;
            ST_MEM:    if (stage_done) state_next = ST_WRITE;
            ST_WRITE:  if (stage_done) state_next = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT:   if (!halt_req) state_next = ST_FETCH;
            default:   state_next = ST_ERROR;
        endcase
        if (is_stage(state_reg) && !stage_done && wd_expire) begin
            state_next = ST_ERROR;
        end
    end

    // Output decode from the next state so the outputs can be registered.
    always_comb begin
        en_next = '0;
        for (int i = 0; i < 5; i++) begin
            en_next[i] = (stage_code(state_next) == 3'(i + 1)) && (state_next != state_reg);
        end
        busy_next   = is_stage(state_next);
        halted_next = (state_next == ST_HALT);
    end

    // Registered status outputs and the sticky watchdog error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_reg        <= '0;
            busy_reg      <= 1'b0;
            halted_reg    <= 1'b0;
            error_reg     <= 1'b0;
            err_stage_reg <= STG_NONE;
        end else begin
            en_reg     <= en_next;
            busy_reg   <= busy_next;
            halted_reg <= halted_next;
            if ((state_next == ST_ERROR) && (state_reg != ST_ERROR)) begin
                error_reg     <= 1'b1;
                err_stage_reg <= stage_code(state_reg);
            end
        end
    end

    // PC, branch-target latch, mem_skip latch and retire counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_reg      <= RESET_PC;
            jump_reg    <= 1'b0;
            target_reg  <= '0;
            skip_reg    <= 1'b0;
            retired_reg <= '0;
        end else begin
            if ((state_reg == ST_DECODE) && stage_done) begin
                skip_reg <= mem_skip;
            end
            if (write_fire) begin
                jump_reg    <= 1'b0;
                retired_reg <= retired_reg + CNT_W'(1);
                if (pcenable) begin
                    pc_reg <= next_pc;
                end else if (jump_reg) begin
                    pc_reg <= target_reg;
                end else begin
                    pc_reg <= pc_reg + PC_STEP;
                end
            end else if ((state_reg == ST_WRITE) && pcenable) begin
                jump_reg   <= 1'b1;
                target_reg <= next_pc;
            end
        end
    end

    assign fetch_enable  = en_reg[0];
    assign decode_enable = en_reg[1];
    assign exec_enable   = en_reg[2];
    assign mem_enable    = en_reg[3];
    assign write_enable  = en_reg[4];
    assign pc            = pc_reg;
    assign busy          = busy_reg;
    assign halted        = halted_reg;
    assign error         = error_reg;
    assign err_stage     = err_stage_reg;
    assign retired       = retired_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: a stage responder drives done pulses
// with random latencies while an architectural model tracks pc and retires.
module tb_core_sequencer;

    localparam logic [31:0] RST_PC = 32'hFFFFFFFC;
    localparam int          TMO    = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0;
    logic        fetch_done = 1'b0, decode_done = 1'b0, exec_done = 1'b0;
    logic        mem_done = 1'b0, write_done = 1'b0, mem_skip = 1'b0;
    logic        pcenable = 1'b0;
    logic [31:0] next_pc = '0;
    logic        fetch_enable, decode_enable, exec_enable, mem_enable, write_enable;
    logic [31:0] pc;
    logic        busy, halted, error;
    logic [2:0]  err_stage;
    logic [31:0] retired;

    int          checks = 0, failures = 0, cyc = 0, last_fetch = 0, n_instr = 0;
    logic [31:0] m_pc;
    int unsigned m_retired;

    always #5 clk = ~clk;

    core_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .halt_req      (halt_req),
        .fetch_enable  (fetch_enable),
        .fetch_done    (fetch_done),
        .decode_enable (decode_enable),
        .decode_done   (decode_done),
        .mem_skip      (mem_skip),
        .exec_enable   (exec_enable),
        .exec_done     (exec_done),
        .mem_enable    (mem_enable),
        .mem_done      (mem_done),
        .write_enable  (write_enable),
        .write_done    (write_done),
        .pcenable      (pcenable),
        .next_pc       (next_pc),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .error         (error),
        .err_stage     (err_stage),
        .retired       (retired)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [4:0] en_vec();
        return {write_enable, mem_enable, exec_enable, decode_enable, fetch_enable};
    endfunction

    task automatic set_done(input int stg, input logic v);
        case (stg)
            0: fetch_done  = v;
            1: decode_done = v;
            2: exec_done   = v;
            3: mem_done    = v;
            default: write_done = v;
        endcase
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pc"}, pc, RST_PC);
        check_eq({tag, "_en"}, en_vec(), 0);
        check_eq({tag, "_flags"}, {busy, halted, error}, 0);
        check_eq({tag, "_err_stage"}, err_stage, 0);
        check_eq({tag, "_retired"}, retired, 0);
    endtask

    // Serve one stage: entered at the negedge where its enable must be seen,
    // done is raised lat cycles later (optionally also a spurious done in the
    // enable cycle, which must be ignored).
    task automatic run_stage(input int stg, input int lat, input bit skip,
                             input int jm, input logic [31:0] tgt);
        bit spur;
        spur = ($urandom_range(0, 3) == 0);
        check_eq($sformatf("enable_stage%0d", stg), en_vec(), 5'b00001 << stg);
        check_eq("pc_stable", pc, m_pc);
        check_eq("busy", busy, 1);
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) check_eq("single_pulse", en_vec(), 0);
            set_done(stg, (c == lat) || (c == 0 && spur));
            mem_skip = (stg == 1 && c == lat) ? skip : 1'($urandom);
            if (stg == 4) begin
                pcenable = 1'b0;
                next_pc  = $urandom;
                if ((jm == 1 || jm == 3) && c == lat - 1) begin
                    pcenable = 1'b1;
                    next_pc  = (jm == 1) ? tgt : $urandom;
                end
                if ((jm == 2 || jm == 3) && c == lat) begin
                    pcenable = 1'b1;
                    next_pc  = tgt;
                end
            end else begin
                pcenable = 1'($urandom);
                next_pc  = $urandom;
            end
            tick();
        end
        set_done(stg, 1'b0);
        pcenable = 1'b0;
        if (stg == 4) begin
            m_pc = (jm != 0) ? tgt : m_pc + 32'd4;
            m_retired++;
            check_eq("pc_after_write", pc, m_pc);
            check_eq("retired", retired, m_retired);
        end
    endtask

    // One full instruction. fixlat=0 picks random latencies; jm selects no
    // branch (0), early pcenable (1), coincident (2) or both (3).
    task automatic do_instr(input int fixlat, input bit skip, input int jm,
                            input logic [31:0] tgt, input bit hlt, input bit chk_per);
        int lat [5];
        for (int i = 0; i < 5; i++) lat[i] = (fixlat != 0) ? fixlat : int'($urandom_range(1, TMO - 1));
        $display("instr %0d pc=%08h skip=%0d jump=%0d tgt=%08h halt=%0d", n_instr, m_pc, skip, jm, tgt, hlt);
        n_instr++;
        if (chk_per) check_eq("fetch_period", cyc - last_fetch, 10);
        last_fetch = cyc;
        run_stage(0, lat[0], skip, jm, tgt);
        run_stage(1, lat[1], skip, jm, tgt);
        if (hlt) halt_req = 1'b1;
        run_stage(2, lat[2], skip, jm, tgt);
        if (!skip) run_stage(3, lat[3], skip, jm, tgt);
        run_stage(4, lat[4], skip, jm, tgt);
        if (hlt) begin
            repeat (3) begin
                check_eq("halted", halted, 1);
                check_eq("halt_quiet", {busy, en_vec()}, 0);
                tick();
            end
            halt_req = 1'b0;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        m_pc = RST_PC;
        m_retired = 0;
        repeat (2) tick();
        check_reset_values("reset");
        rstn = 1'b1;
        tick();

        // Start with halt pending goes to HALT, release fetches from RESET_PC.
        halt_req = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("idle_to_halt", {halted, busy}, 2'b10);
        tick();
        check_eq("halt_hold", halted, 1);
        halt_req = 1'b0;
        tick();

        // Minimum-latency instructions, first one wraps the PC.
        do_instr(1, 0, 0, 32'h0, 0, 0);
        do_instr(1, 0, 0, 32'h0, 0, 1);
        do_instr(1, 0, 0, 32'h0, 0, 1);
        do_instr(1, 1, 0, 32'h0, 0, 0);
        // Branch early, coincident, both; then sequential after target.
        do_instr(0, 0, 1, 32'h100, 0, 0);
        do_instr(0, 0, 2, 32'h100, 0, 0);
        do_instr(0, 1, 3, 32'h100, 0, 0);
        do_instr(0, 0, 0, 32'h0, 0, 0);
        // Halt requested during exec.
        do_instr(0, 0, 0, 32'h0, 1, 0);
        // Every done lands exactly in the watchdog expiry cycle.
        do_instr(TMO - 1, 0, 0, 32'h0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            do_instr(0, 1'($urandom), int'($urandom_range(0, 3)),
                     $urandom & 32'hFFFFFFFC, ($urandom_range(0, 5) == 0), 0);
        end

        // Reset in the middle of DECODE.
        run_stage(0, 2, 0, 0, 32'h0);
        check_eq("decode_entry", en_vec(), 5'b00010);
        tick();
        #2 rstn = 1'b0;
        #1 check_reset_values("async_reset");
        m_pc = RST_PC;
        m_retired = 0;
        tick();
        rstn = 1'b1;
        decode_done = 1'b1;
        tick();
        decode_done = 1'b0;
        check_eq("late_done_ignored", {busy, en_vec()}, 0);
        check_eq("late_done_pc", pc, RST_PC);

        // Watchdog: exec_done withheld.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_stage(0, 1, 0, 0, 32'h0);
        run_stage(1, 1, 0, 0, 32'h0);
        check_eq("exec_entry", en_vec(), 5'b00100);
        for (int c = 1; c <= TMO; c++) begin
            tick();
            if (c < TMO) check_eq("no_error_yet", {error, busy}, 2'b01);
        end
        check_eq("error_set", error, 1);
        check_eq("err_stage", err_stage, 3);
        check_eq("error_idle", {busy, halted, en_vec()}, 0);
        exec_done = 1'b1;
        start = 1'b1;
        tick();
        exec_done = 1'b0;
        start = 1'b0;
        repeat (3) begin
            tick();
            check_eq("error_sticky", {error, err_stage}, 4'b1011);
            check_eq("error_quiet", {busy, en_vec()}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
